// File: rtl/mc_ctrl_pkg.sv
// Shared state, opcode, funct and ALU constants for the multicycle control FSM.
// Defining MC_CTRL_IMM_LOGIC_EN adds ANDI/ORI/SLTI as immediate-class opcodes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExec,
    StAluWb, StBranch, StImmExec, StImmWb, StJump, StTrap
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpSlti = 6'b001010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // ALU operation class requested by the FSM; None drives a zero code.
  localparam logic [2:0] AluOpNone  = 3'd0;
  localparam logic [2:0] AluOpAdd   = 3'd1;
  localparam logic [2:0] AluOpSub   = 3'd2;
  localparam logic [2:0] AluOpFunct = 3'd3;
  localparam logic [2:0] AluOpImm   = 3'd4;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       iord;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_imm_op(logic [5:0] op);
`ifdef MC_CTRL_IMM_LOGIC_EN
    return (op == OpAddi) || (op == OpAndi) || (op == OpOri) || (op == OpSlti);
`else
    return op == OpAddi;
`endif
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU decoder: maps the FSM's ALU class plus opcode/funct to an ALU code.
// With MC_CTRL_IMM_LOGIC_EN it also decodes logic immediates and drives zero_ext.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       zero_ext
);

  always_comb begin
    alu_ctrl = AluAnd;
    zero_ext = 1'b0;
    case (alu_op)
      AluOpAdd: alu_ctrl = AluAdd;
      AluOpSub: alu_ctrl = AluSub;
      AluOpFunct: begin
        case (funct)
          FnSub:   alu_ctrl = AluSub;
          FnAnd:   alu_ctrl = AluAnd;
          FnOr:    alu_ctrl = AluOr;
          FnSlt:   alu_ctrl = AluSlt;
          default: alu_ctrl = AluAdd;
        endcase
      end
      AluOpImm: begin
`ifdef MC_CTRL_IMM_LOGIC_EN
        case (opcode)
          OpAndi: begin
            alu_ctrl = AluAnd;
            zero_ext = 1'b1;
          end
          OpOri: begin
            alu_ctrl = AluOr;
            zero_ext = 1'b1;
          end
          OpSlti:  alu_ctrl = AluSlt;
          default: alu_ctrl = AluAdd;
        endcase
`else
        alu_ctrl = AluAdd;
`endif
      end
      default: ;
    endcase
  end

`ifndef MC_CTRL_IMM_LOGIC_EN
  logic unused_opcode;
  assign unused_opcode = ^opcode;
`endif

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-style control FSM with memory wait timeout and a trap state.
// Optional MC_CTRL_IMM_LOGIC_EN enables ANDI/ORI/SLTI through the immediate path.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT   = 15,
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  branch,
  output logic                  branch_ne,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic                  mem_to_reg,
  output logic                  reg_dst,
  output logic                  reg_write,
  output logic                  IorD,
  output logic                  ir_write,
  output logic                  alu_src_A,
  output logic                  zero_ext,
  output logic [1:0]            pc_src,
  output logic [1:0]            alu_src_B,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  instr_done,
  output logic                  illegal_op,
  output logic                  mem_timeout
);

  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q;
  logic       mem_timeout_q;
  logic       is_wait, wait_expire, op_legal, ready_ok;
  ctrl_t      ctrl;
  logic [2:0] alu_ctrl;

  assign is_wait     = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  // Ready on the expiring cycle still completes the access.
  assign wait_expire = !mem_ready && (wait_cnt_q == WaitLast);
  assign op_legal    = (opcode inside {OpR, OpLw, OpSw, OpBeq, OpBne, OpJ}) || is_imm_op(opcode);
  // Keeps ready-qualified strobes low while reset holds the FSM in FETCH.
  assign ready_ok    = mem_ready & rstn;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready)        state_d = StDecode;
        else if (wait_expire) state_d = StTrap;
      end
      StDecode: begin
        if (opcode == OpLw || opcode == OpSw)        state_d = StMemAdr;
        else if (opcode == OpR)                      state_d = StExec;
        else if (opcode == OpBeq || opcode == OpBne) state_d = StBranch;
        else if (is_imm_op(opcode))                  state_d = StImmExec;
        else if (opcode == OpJ)                      state_d = StJump;
        else                                         state_d = StFetch;
      end
      StMemAdr:  state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
      StMemRead: begin
        if (mem_ready)        state_d = StMemWb;
        else if (wait_expire) state_d = StTrap;
      end
      StMemWrite: begin
        if (mem_ready)        state_d = StFetch;
        else if (wait_expire) state_d = StTrap;
      end
      StExec:    state_d = StAluWb;
      StImmExec: state_d = StImmWb;
      StMemWb, StAluWb, StImmWb, StBranch, StJump: state_d = StFetch;
      StTrap:    state_d = StTrap;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StFetch;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        wait_cnt_q <= '0;
      end else if (is_wait && !mem_ready) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
      if (state_d == StTrap) begin
        mem_timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.pc_write  = ready_ok;
        ctrl.ir_write  = ready_ok;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = AluOpAdd;
      end
      StDecode: begin
        ctrl.alu_src_b  = 2'b11;
        ctrl.alu_op     = AluOpAdd;
        ctrl.illegal_op = !op_legal;
      end
      StMemAdr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = AluOpAdd;
      end
      StMemRead: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StMemWrite: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = ready_ok;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = AluOpFunct;
      end
      StAluWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = AluOpSub;
        ctrl.pc_src     = 2'b01;
        ctrl.branch     = (opcode == OpBeq);
        ctrl.branch_ne  = (opcode == OpBne);
        ctrl.instr_done = 1'b1;
      end
      StImmExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = AluOpImm;
      end
      StImmWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StJump: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = 2'b10;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .alu_op   (ctrl.alu_op),
    .opcode   (opcode),
    .funct    (funct),
    .alu_ctrl (alu_ctrl),
    .zero_ext (zero_ext)
  );

  assign pc_write    = ctrl.pc_write;
  assign branch      = ctrl.branch;
  assign branch_ne   = ctrl.branch_ne;
  assign mem_write   = ctrl.mem_write;
  assign mem_read    = ctrl.mem_read;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign reg_dst     = ctrl.reg_dst;
  assign reg_write   = ctrl.reg_write;
  assign IorD        = ctrl.iord;
  assign ir_write    = ctrl.ir_write;
  assign alu_src_A   = ctrl.alu_src_a;
  assign pc_src      = ctrl.pc_src;
  assign alu_src_B   = ctrl.alu_src_b;
  assign alu_control = ALU_CTRL_W'(alu_ctrl);
  assign instr_done  = ctrl.instr_done;
  assign illegal_op  = ctrl.illegal_op;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-cycle expected output vectors are queued when
// inputs are driven and compared on the following falling edge.
module tb_mc_ctrl_fsm;

  localparam int unsigned MaxWait = 4;

  localparam logic [5:0] TOpR    = 6'b000000;
  localparam logic [5:0] TOpLw   = 6'b100011;
  localparam logic [5:0] TOpSw   = 6'b101011;
  localparam logic [5:0] TOpBeq  = 6'b000100;
  localparam logic [5:0] TOpBne  = 6'b000101;
  localparam logic [5:0] TOpAddi = 6'b001000;
  localparam logic [5:0] TOpJ    = 6'b000010;
  localparam logic [5:0] TOpAndi = 6'b001100;
  localparam logic [5:0] TOpOri  = 6'b001101;
  localparam logic [5:0] TOpSlti = 6'b001010;
  localparam logic [5:0] TOpBad  = 6'b111111;

  typedef enum {
    BFetch, BDecode, BMemAdr, BMemRead, BMemWb, BMemWrite, BExec, BAluWb,
    BBranch, BImmExec, BImmWb, BJump, BTrap
  } bst_e;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       pc_write, branch, branch_ne, mem_write, mem_read, mem_to_reg, reg_dst;
  logic       reg_write, IorD, ir_write, alu_src_A, zero_ext;
  logic [1:0] pc_src, alu_src_B;
  logic [2:0] alu_control;
  logic       instr_done, illegal_op, mem_timeout;

  int          n_checks = 0;
  int          n_pass   = 0;
  string       scen     = "init";
  string       tag_q[$];
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  mc_ctrl_fsm #(
    .MAX_WAIT   (MaxWait),
    .ALU_CTRL_W (3)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .opcode      (opcode),
    .funct       (funct),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .branch      (branch),
    .branch_ne   (branch_ne),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_to_reg  (mem_to_reg),
    .reg_dst     (reg_dst),
    .reg_write   (reg_write),
    .IorD        (IorD),
    .ir_write    (ir_write),
    .alu_src_A   (alu_src_A),
    .zero_ext    (zero_ext),
    .pc_src      (pc_src),
    .alu_src_B   (alu_src_B),
    .alu_control (alu_control),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %06h expected %06h", tag, obs, exp);
  endtask

  function automatic logic [21:0] obs_vec();
    return {pc_write, branch, branch_ne, mem_write, mem_read, mem_to_reg, reg_dst, reg_write,
            IorD, ir_write, alu_src_A, zero_ext, pc_src, alu_src_B, alu_control,
            instr_done, illegal_op, mem_timeout};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    logic ok;
    ok = (op == TOpR) || (op == TOpLw) || (op == TOpSw) || (op == TOpBeq) ||
         (op == TOpBne) || (op == TOpAddi) || (op == TOpJ);
`ifdef MC_CTRL_IMM_LOGIC_EN
    ok = ok || (op == TOpAndi) || (op == TOpOri) || (op == TOpSlti);
`endif
    return ok;
  endfunction

  // Expected outputs for a state, straight from the control table.
  function automatic logic [21:0] ev(input bst_e st, input logic rdy);
    logic pcw, br, brn, mw, mr, m2r, rd, rw, iord, irw, asa, zx, done, ill, to;
    logic [1:0] ps, asb;
    logic [2:0] alu;
    logic       r;
    {pcw, br, brn, mw, mr, m2r, rd, rw, iord, irw, asa, zx, done, ill, to} = '0;
    ps = '0; asb = '0; alu = '0;
    r = rdy & rstn;
    case (st)
      BFetch:   begin mr = 1; pcw = r; irw = r; asb = 2'b01; alu = 3'b010; end
      BDecode:  begin asb = 2'b11; alu = 3'b010; ill = !is_legal(opcode); end
      BMemAdr:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
      BMemRead: begin mr = 1; iord = 1; end
      BMemWb:   begin rw = 1; m2r = 1; done = 1; end
      BMemWrite: begin mw = 1; iord = 1; done = r; end
      BExec: begin
        asa = 1;
        case (funct)
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   alu = 3'b010;
        endcase
      end
      BAluWb:  begin rw = 1; rd = 1; done = 1; end
      BBranch: begin
        asa = 1; alu = 3'b110; ps = 2'b01; done = 1;
        br = (opcode == TOpBeq); brn = (opcode == TOpBne);
      end
      BImmExec: begin
        asa = 1; asb = 2'b10; alu = 3'b010;
`ifdef MC_CTRL_IMM_LOGIC_EN
        if (opcode == TOpAndi) begin alu = 3'b000; zx = 1; end
        if (opcode == TOpOri)  begin alu = 3'b001; zx = 1; end
        if (opcode == TOpSlti) alu = 3'b111;
`endif
      end
      BImmWb: begin rw = 1; done = 1; end
      BJump:  begin pcw = 1; ps = 2'b10; done = 1; end
      BTrap:  to = 1;
      default: ;
    endcase
    return {pcw, br, brn, mw, mr, m2r, rd, rw, iord, irw, asa, zx, ps, asb, alu, done, ill, to};
  endfunction

  task automatic cyc(input bst_e st, input logic rdy);
    mem_ready = rdy;
    tag_q.push_back($sformatf("%s/%s", scen, st.name()));
    exp_q.push_back(ev(st, rdy));
    @(posedge clk);
    #1;
  endtask

  // One full instruction with memory always ready.
  task automatic run_instr(input logic [5:0] op);
    opcode = op;
    scen = $sformatf("op%06b", op);
    cyc(BFetch, 1'b1);
    cyc(BDecode, 1'b1);
    if (op == TOpLw) begin
      cyc(BMemAdr, 1'b1); cyc(BMemRead, 1'b1); cyc(BMemWb, 1'b1);
    end else if (op == TOpSw) begin
      cyc(BMemAdr, 1'b1); cyc(BMemWrite, 1'b1);
    end else if (op == TOpR) begin
      cyc(BExec, 1'b1); cyc(BAluWb, 1'b1);
    end else if (op == TOpBeq || op == TOpBne) begin
      cyc(BBranch, 1'b1);
    end else if (op == TOpJ) begin
      cyc(BJump, 1'b1);
    end else if (is_legal(op)) begin
      cyc(BImmExec, 1'b1); cyc(BImmWb, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check_eq(tag_q.pop_front(), 32'(obs_vec()), 32'(exp_q.pop_front()));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fns[5];
    logic [5:0] ops[11];
    fns = '{6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    ops = '{TOpLw, TOpSw, TOpR, TOpBeq, TOpBne, TOpAddi, TOpJ, TOpAndi, TOpOri, TOpSlti, TOpBad};
    rstn = 1'b0; mem_ready = 1'b1; opcode = TOpLw; funct = 6'b100000;
    @(posedge clk);
    #1;
    scen = "reset";
    cyc(BFetch, 1'b1);
    cyc(BFetch, 1'b0);
    rstn = 1'b1;

    run_instr(TOpLw);

    scen = "fetch_wait"; opcode = TOpR; funct = 6'b100010;
    repeat (3) cyc(BFetch, 1'b0);
    cyc(BFetch, 1'b1); cyc(BDecode, 1'b1); cyc(BExec, 1'b1); cyc(BAluWb, 1'b1);

    for (int i = 0; i < 5; i++) begin
      funct = fns[i];
      run_instr(TOpR);
    end
    for (int i = 0; i < 11; i++) run_instr(ops[i]);

    scen = "rd_edge"; opcode = TOpLw;
    cyc(BFetch, 1'b1); cyc(BDecode, 1'b1); cyc(BMemAdr, 1'b1);
    repeat (MaxWait - 1) cyc(BMemRead, 1'b0);
    cyc(BMemRead, 1'b1); cyc(BMemWb, 1'b1);

    scen = "rst_rd";
    cyc(BFetch, 1'b1); cyc(BDecode, 1'b1); cyc(BMemAdr, 1'b1);
    cyc(BMemRead, 1'b0); cyc(BMemRead, 1'b0);
    rstn = 1'b0;
    #1;
    check_eq("rst_rd_async", 32'(obs_vec()), 32'(ev(BFetch, mem_ready)));
    cyc(BFetch, 1'b1);
    rstn = 1'b1;
    scen = "post_rst_wait";
    repeat (MaxWait - 1) cyc(BFetch, 1'b0);
    cyc(BFetch, 1'b1); cyc(BDecode, 1'b1); cyc(BMemAdr, 1'b1);
    cyc(BMemRead, 1'b1); cyc(BMemWb, 1'b1);

    scen = "rst_wr"; opcode = TOpSw;
    cyc(BFetch, 1'b1); cyc(BDecode, 1'b1); cyc(BMemAdr, 1'b1); cyc(BMemWrite, 1'b0);
    rstn = 1'b0;
    #1;
    check_eq("rst_wr_async", 32'(obs_vec()), 32'(ev(BFetch, mem_ready)));
    cyc(BFetch, 1'b0);
    rstn = 1'b1;

    scen = "trap";
    cyc(BFetch, 1'b1); cyc(BDecode, 1'b1); cyc(BMemAdr, 1'b1);
    repeat (MaxWait) cyc(BMemWrite, 1'b0);
    cyc(BTrap, 1'b1); cyc(BTrap, 1'b0); cyc(BTrap, 1'b1);
    rstn = 1'b0;
    #1;
    check_eq("rst_trap_async", 32'(obs_vec()), 32'(ev(BFetch, mem_ready)));
    cyc(BFetch, 1'b1);
    rstn = 1'b1;
    run_instr(TOpLw);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
